// File: rtl/data_sync_rx_if.sv
// rtl/data_sync_rx_if.sv - req/ack bus bundle for data_sync_rx; PARITY_CHECK_EN adds UNSYNC_PAR/PAR_ERR
interface data_sync_rx_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 UNSYNC_REQ;
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;
    logic                 SYNC_ACK;
    logic                 BUSY;
`ifdef PARITY_CHECK_EN
    logic                 UNSYNC_PAR;
    logic                 PAR_ERR;

    modport master (
        output UNSYNC_REQ, UNSYNC_BUS, UNSYNC_PAR,
        input  SYNC_BUS, ENABLE_PULSE, SYNC_ACK, BUSY, PAR_ERR
    );
    modport slave (
        input  UNSYNC_REQ, UNSYNC_BUS, UNSYNC_PAR,
        output SYNC_BUS, ENABLE_PULSE, SYNC_ACK, BUSY, PAR_ERR
    );
`else
    modport master (
        output UNSYNC_REQ, UNSYNC_BUS,
        input  SYNC_BUS, ENABLE_PULSE, SYNC_ACK, BUSY
    );
    modport slave (
        input  UNSYNC_REQ, UNSYNC_BUS,
        output SYNC_BUS, ENABLE_PULSE, SYNC_ACK, BUSY
    );
`endif
endinterface

// File: rtl/data_sync_rx.sv
// rtl/data_sync_rx.sv - four-phase req/ack receiver into CLK; optional PARITY_CHECK_EN word parity check
module data_sync_rx #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic          CLK,
    input  logic          RST,
    data_sync_rx_if.slave bus
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_STAGES-1:0] req_sync;
    logic                  req_s;
    logic                  capture;
    logic                  load_bus;
    logic                  ack_nxt;
    logic                  pulse_nxt;
    logic                  par_bad;
    logic [BUS_WIDTH-1:0]  sync_bus_q;
    logic                  enable_pulse_q;
    logic                  sync_ack_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[NUM_STAGES-2:0], bus.UNSYNC_REQ};
        end
    end

    assign req_s = req_sync[NUM_STAGES-1];

`ifdef PARITY_CHECK_EN
    assign par_bad = ^{bus.UNSYNC_BUS, bus.UNSYNC_PAR};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A single capture per REQ high phase: ACK is left only once req_s is seen low.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_nxt   = sync_ack_q;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_nxt = ACK;
                    capture   = 1'b1;
                    ack_nxt   = 1'b1;
                    pulse_nxt = !par_bad;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end else begin
                    ack_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_bus = capture && !par_bad;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
            sync_ack_q     <= 1'b0;
        end else begin
            enable_pulse_q <= pulse_nxt;
            sync_ack_q     <= ack_nxt;
            if (load_bus) begin
                sync_bus_q <= bus.UNSYNC_BUS;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_err_q;

    // Flag describes the most recent capture only; a clean word clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_q <= 1'b0;
        end else if (capture) begin
            par_err_q <= par_bad;
        end
    end

    assign bus.PAR_ERR = par_err_q;
`endif

    assign bus.SYNC_BUS     = sync_bus_q;
    assign bus.ENABLE_PULSE = enable_pulse_q;
    assign bus.SYNC_ACK     = sync_ack_q;
    assign bus.BUSY         = (state != IDLE);
endmodule

// File: tb/tb_data_sync_rx.sv
// tb/tb_data_sync_rx.sv - scoreboard bench for data_sync_rx; PARITY_CHECK_EN enables parity cases
`timescale 1ns/1ps
module tb_data_sync_rx;
    localparam int NS = 2;
    localparam int BW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pulse = 0;
    logic [BW-1:0] exp_q[$];

    data_sync_rx_if #(.BUS_WIDTH(BW)) sif ();

    data_sync_rx #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (sif)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding word.
    always @(posedge CLK) begin
        #1;
        if (RST && sif.ENABLE_PULSE) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(1), 32'(0));
            end else begin
                check("sb_sync_bus", 32'(sif.SYNC_BUS), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_par(input logic p);
`ifdef PARITY_CHECK_EN
        sif.UNSYNC_PAR = p;
`else
        if (p) begin end
`endif
    endtask

    task automatic wait_ack(input logic val, input string tag);
        for (int i = 0; i < 20 && sif.SYNC_ACK !== val; i++) tick();
        check(tag, 32'(sif.SYNC_ACK), 32'(val));
    endtask

    task automatic transfer(input logic [BW-1:0] w, input logic p, input logic good);
        sif.UNSYNC_BUS = w;
        set_par(p);
        if (good) exp_q.push_back(w);
        sif.UNSYNC_REQ = 1'b1;
        wait_ack(1'b1, "ack_rise");
        sif.UNSYNC_REQ = 1'b0;
        wait_ack(1'b0, "ack_fall");
        tick();
        tick();
    endtask

    initial begin
        sif.UNSYNC_REQ = 1'b0;
        sif.UNSYNC_BUS = '0;
        set_par(1'b0);
        tick();
        tick();
        RST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", 32'({sif.SYNC_BUS, sif.ENABLE_PULSE, sif.SYNC_ACK, sif.BUSY}), 32'(0));
        end

        // Latency: REQ changes just after edge 0, pulse visible after edge NS+1.
        sif.UNSYNC_BUS = 8'hA5;
        set_par(1'b0);
        exp_q.push_back(8'hA5);
        sif.UNSYNC_REQ = 1'b1;
        for (int i = 1; i <= NS + 1; i++) begin
            tick();
            check("rise_pulse", 32'(sif.ENABLE_PULSE), 32'(i == NS + 1));
            check("rise_ack", 32'(sif.SYNC_ACK), 32'(i == NS + 1));
        end
        check("rise_bus", 32'(sif.SYNC_BUS), 32'(8'hA5));
        tick();
        check("pulse_width", 32'(sif.ENABLE_PULSE), 32'(0));
        check("busy_in_ack", 32'(sif.BUSY), 32'(1));

        // Bus changes while REQ stays high: must not be resampled.
        sif.UNSYNC_BUS = 8'h3C;
        for (int i = 0; i < 50; i++) tick();
        check("hold_bus", 32'(sif.SYNC_BUS), 32'(8'hA5));
        check("hold_ack", 32'(sif.SYNC_ACK), 32'(1));
        check("hold_pulses", 32'(n_pulse), 32'(1));

        sif.UNSYNC_REQ = 1'b0;
        for (int i = 1; i <= NS + 1; i++) begin
            tick();
            check("fall_ack", 32'(sif.SYNC_ACK), 32'(i < NS + 1));
        end
        check("fall_busy", 32'(sif.BUSY), 32'(0));
        tick();
        tick();

        for (int k = 1; k <= 3; k++) transfer(BW'(k), 1'b0, 1'b1);
        check("b2b_pulses", 32'(n_pulse), 32'(4));
        check("b2b_last", 32'(sif.SYNC_BUS), 32'(8'h03));

`ifdef PARITY_CHECK_EN
        transfer(8'h07, 1'b0, 1'b0);
        check("par_err_set", 32'(sif.PAR_ERR), 32'(1));
        check("par_bus_kept", 32'(sif.SYNC_BUS), 32'(8'h03));
        check("par_no_pulse", 32'(n_pulse), 32'(4));
        transfer(8'h07, 1'b1, 1'b1);
        check("par_err_clr", 32'(sif.PAR_ERR), 32'(0));
        check("par_bus_new", 32'(sif.SYNC_BUS), 32'(8'h07));
        check("par_pulse", 32'(n_pulse), 32'(5));
`endif

        // Reset in ACK with REQ high, then recapture of the same word.
        sif.UNSYNC_BUS = 8'h5A;
        set_par(1'b0);
        exp_q.push_back(8'h5A);
        sif.UNSYNC_REQ = 1'b1;
        wait_ack(1'b1, "pre_rst_ack");
        tick();
        #2;
        RST = 1'b0;
        #1;
        check("rst_outputs", 32'({sif.SYNC_BUS, sif.ENABLE_PULSE, sif.SYNC_ACK, sif.BUSY}), 32'(0));
        exp_q.push_back(8'h5A);
        tick();
        #2;
        RST = 1'b1;
        for (int i = 1; i <= NS + 1; i++) begin
            tick();
            check("recap_pulse", 32'(sif.ENABLE_PULSE), 32'(i == NS + 1));
        end
        check("recap_bus", 32'(sif.SYNC_BUS), 32'(8'h5A));
        sif.UNSYNC_REQ = 1'b0;
        wait_ack(1'b0, "recap_fall");
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_sync_rx.md
# data_sync_rx

Destination-side receiver for a four-phase request/acknowledge bus crossing into the CLK domain. It synchronizes an asynchronous request and captures a multi-bit bus that the source holds stable. It presents the word with a one-cycle ENABLE_PULSE and returns a registered acknowledge for the source domain to synchronize. It sits between the UART RX domain and the system-clock register file, alongside the reset synchronizer that drives its RST.

## Interface
- NUM_STAGES, 2: request synchronizer depth; legal values are 2..4.
- BUS_WIDTH, 8: width of the transferred word.

- CLK  input  1  destination clock.
- RST  input  1  reset, asynchronous, active-low.
- UNSYNC_REQ  input  1  request from the source domain; asynchronous to CLK.
- UNSYNC_BUS  input  BUS_WIDTH  data word; the source holds it stable from REQ rise until it sees SYNC_ACK high.
- UNSYNC_PAR  input  1  even-parity bit over UNSYNC_BUS. Present only with PARITY_CHECK_EN.
- SYNC_BUS  output  BUS_WIDTH  last accepted word, registered.
- ENABLE_PULSE  output  1  one-cycle strobe when SYNC_BUS is updated.
- SYNC_ACK  output  1  registered acknowledge back to the source.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- PAR_ERR  output  1  sticky-per-transfer parity error flag. Present only with PARITY_CHECK_EN.

## Operation
- Request synchronizer: a NUM_STAGES flop chain, with all flops reset to 0. Its last stage is req_s.
- FSM states: IDLE, ACK.
  - IDLE with req_s=1 moves to ACK. On that edge:
    - SYNC_BUS <= UNSYNC_BUS.
    - ENABLE_PULSE <= 1.
    - SYNC_ACK <= 1.
  - ACK:
    - ENABLE_PULSE <= 0 on the next edge.
    - SYNC_ACK stays 1 while req_s=1.
    - When req_s=0, the FSM returns to IDLE and SYNC_ACK <= 0.
  - IDLE with req_s=0 holds all outputs.
- Only one capture occurs per REQ high phase. REQ must fall and be seen low before the next word is captured.
- SYNC_BUS holds its value between transfers. UNSYNC_BUS is never sampled outside the IDLE->ACK edge.
- BUSY = (state != IDLE), driven combinationally from the state register.
- Reset values: SYNC_BUS=0, ENABLE_PULSE=0, SYNC_ACK=0, BUSY=0, PAR_ERR=0, synchronizer chain=0, state=IDLE.
- Reset mid-transfer clears everything immediately. If REQ is still high after reset release, the FSM captures it as a new transfer; the source protocol tolerates this duplicate.
- A REQ glitch shorter than one CLK period may be missed. If it propagates through the chain, it is captured as a complete transfer.

## Timing
- REQ rise to ENABLE_PULSE/SYNC_ACK high: NUM_STAGES+1 rising edges, plus up to one cycle of sampling uncertainty.
- ENABLE_PULSE width: exactly 1 CLK cycle. It is coincident with the first SYNC_ACK cycle and with the new SYNC_BUS value.
- REQ fall to SYNC_ACK low: NUM_STAGES+1 edges.
- Minimum IDLE dwell between transfers: 1 cycle.
- Full handshake cost in the CLK domain: at least 2*(NUM_STAGES+1) cycles, plus source-side synchronization.
- All outputs are flop-driven except BUSY, which is decoded from the state flop only.

## Configuration
- Macro: PARITY_CHECK_EN.
- With the macro defined:
  - UNSYNC_PAR and PAR_ERR exist.
  - On the IDLE->ACK edge, PAR_ERR <= ^{UNSYNC_BUS, UNSYNC_PAR}.
  - On a parity error, SYNC_BUS is not updated and ENABLE_PULSE stays 0, but SYNC_ACK still asserts so the handshake completes.
  - PAR_ERR holds until the next capture edge or reset.
- Without the macro:
  - Both ports are absent.
  - Every capture updates SYNC_BUS and pulses ENABLE_PULSE.

## Test plan
- Reset then idle, REQ=0 for 20 cycles -> all outputs stay 0 and BUSY=0.
- NUM_STAGES=2, BUS=8'hA5, REQ raised at edge 0 -> ENABLE_PULSE high for exactly one cycle at edge 3 with SYNC_BUS=8'hA5 and SYNC_ACK=1. Drop REQ -> SYNC_ACK=0 three edges later, FSM back in IDLE.
- REQ held high for 50 cycles with the bus changing to 8'h3C after ACK -> a single ENABLE_PULSE, and SYNC_BUS remains 8'hA5.
- Back-to-back words 8'h01, 8'h02, 8'h03 with the full handshake each -> three pulses, SYNC_BUS sequence 01/02/03, no duplicates.
- RST asserted while in ACK with REQ high -> outputs 0 immediately. After release, recapture occurs NUM_STAGES+1 edges later.
- PARITY_CHECK_EN: bus 8'h07 with UNSYNC_PAR=0 -> PAR_ERR=1, no ENABLE_PULSE, SYNC_BUS unchanged, SYNC_ACK still handshakes. Then 8'h07 with UNSYNC_PAR=1 -> PAR_ERR=0, a pulse, and SYNC_BUS=8'h07.
